// File: rtl/ex_operand_stage.sv
// ID/EX register plus RAW forwarding from EX/MEM and MEM/WB.
// Drives ALUOperation/A/B/EX_StoreData; ForwardA/B expose the mux selects.
//
// Ports:
//   clk, reset            clock, sync active-high reset
//   Stall, Flush          hold the stage / load a bubble
//   ID_*                  decoded instruction fields from ID
//   MEM_*, WB_*           write-back info from EX/MEM and MEM/WB
//   EX_Valid              stage holds a real instruction
//   ALUOperation, A, B    ALU control and operands
//   EX_StoreData          forwarded Rt value for stores
//   ForwardA, ForwardB    00 regfile, 01 WB, 10 MEM
module ex_operand_stage #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter logic [3:0]  NOP_OP         = 4'b1111
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      ID_Valid,
  input  logic [3:0]                ID_ALUOperation,
  input  logic                      ID_ALUSrc,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
  input  logic [DATA_WIDTH-1:0]     ID_Immediate,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
  input  logic                      MEM_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WriteRegister,
  input  logic [DATA_WIDTH-1:0]     MEM_ALUResult,
  input  logic                      WB_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WB_WriteRegister,
  input  logic [DATA_WIDTH-1:0]     WB_WriteData,
  output logic                      EX_Valid,
  output logic [3:0]                ALUOperation,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [DATA_WIDTH-1:0]     EX_StoreData,
  output logic [1:0]                ForwardA,
  output logic [1:0]                ForwardB
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic                      valid_q;
  logic [3:0]                op_q;
  logic                      alusrc_q;
  logic [DATA_WIDTH-1:0]     rd1_q;
  logic [DATA_WIDTH-1:0]     rd2_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;

  always_ff @(posedge clk) begin
    if (reset || Flush || (!Stall && !ID_Valid)) begin
      valid_q  <= 1'b0;
      op_q     <= NOP_OP;
      alusrc_q <= 1'b0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
    end else if (!Stall) begin
      valid_q  <= 1'b1;
      op_q     <= ID_ALUOperation;
      alusrc_q <= ID_ALUSrc;
      rd1_q    <= ID_ReadData1;
      rd2_q    <= ID_ReadData2;
      imm_q    <= ID_Immediate;
      rs_q     <= ID_Rs;
      rt_q     <= ID_Rt;
    end
  end

  // MEM wins over WB since it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] src
  );
    logic nz;
    nz = (src != '0);
    if (MEM_RegWrite && nz && MEM_WriteRegister == src)
      fwd_sel = FWD_MEM;
    else if (WB_RegWrite && nz && WB_WriteRegister == src)
      fwd_sel = FWD_WB;
    else
      fwd_sel = FWD_RF;
  endfunction

  logic [1:0]            fa;
  logic [1:0]            fb;
  logic [DATA_WIDTH-1:0] va;
  logic [DATA_WIDTH-1:0] vb;

  always_comb begin
    fa = fwd_sel(rs_q);
    fb = fwd_sel(rt_q);
    va = rd1_q;
    vb = rd2_q;
    unique case (1'b1)
      fa == FWD_MEM: va = MEM_ALUResult;
      fa == FWD_WB:  va = WB_WriteData;
      default:       va = rd1_q;
    endcase
    unique case (1'b1)
      fb == FWD_MEM: vb = MEM_ALUResult;
      fb == FWD_WB:  vb = WB_WriteData;
      default:       vb = rd2_q;
    endcase
  end

  // A bubble presents a clean, inert operand set to the ALU.
  always_comb begin
    EX_Valid     = valid_q;
    ALUOperation = NOP_OP;
    A            = '0;
    B            = '0;
    EX_StoreData = '0;
    ForwardA     = FWD_RF;
    ForwardB     = FWD_RF;
    if (valid_q) begin
      ALUOperation = op_q;
      A            = va;
      B            = alusrc_q ? imm_q : vb;
      EX_StoreData = vb;
      ForwardA     = fa;
      ForwardB     = fb;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Flush;
  logic        ID_Valid;
  logic [3:0]  ID_ALUOperation;
  logic        ID_ALUSrc;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic [31:0] ID_Immediate;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_WriteRegister;
  logic [31:0] MEM_ALUResult;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteRegister;
  logic [31:0] WB_WriteData;
  logic        EX_Valid;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] EX_StoreData;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;

  ex_operand_stage dut (
    .clk(clk),
    .reset(reset),
    .Stall(Stall),
    .Flush(Flush),
    .ID_Valid(ID_Valid),
    .ID_ALUOperation(ID_ALUOperation),
    .ID_ALUSrc(ID_ALUSrc),
    .ID_ReadData1(ID_ReadData1),
    .ID_ReadData2(ID_ReadData2),
    .ID_Immediate(ID_Immediate),
    .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt),
    .MEM_RegWrite(MEM_RegWrite),
    .MEM_WriteRegister(MEM_WriteRegister),
    .MEM_ALUResult(MEM_ALUResult),
    .WB_RegWrite(WB_RegWrite),
    .WB_WriteRegister(WB_WriteRegister),
    .WB_WriteData(WB_WriteData),
    .EX_Valid(EX_Valid),
    .ALUOperation(ALUOperation),
    .A(A),
    .B(B),
    .EX_StoreData(EX_StoreData),
    .ForwardA(ForwardA),
    .ForwardB(ForwardB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    total = 0;
  int    passed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(
    input string       n,
    input logic        v,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] sd,
    input logic [1:0]  fa,
    input logic [1:0]  fb
  );
    exp_t e;
    e.v = v; e.op = op; e.a = a; e.b = b;
    e.sd = sd; e.fa = fa; e.fb = fb;
    q.push_back(e);
    nq.push_back(n);
  endtask

  task automatic expect_bubble(input string n);
    expect_out(n, 1'b0, 4'hF, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic fwd(
    input logic mw, input logic [4:0] mr,
    input logic [31:0] md,
    input logic ww, input logic [4:0] wr,
    input logic [31:0] wd
  );
    MEM_RegWrite = mw; MEM_WriteRegister = mr;
    MEM_ALUResult = md;
    WB_RegWrite = ww; WB_WriteRegister = wr;
    WB_WriteData = wd;
  endtask

  task automatic id(
    input logic v, input logic [3:0] op,
    input logic src,
    input logic [31:0] r1, input logic [31:0] r2,
    input logic [31:0] imm,
    input logic [4:0] rs, input logic [4:0] rt
  );
    ID_Valid = v; ID_ALUOperation = op;
    ID_ALUSrc = src; ID_ReadData1 = r1;
    ID_ReadData2 = r2; ID_Immediate = imm;
    ID_Rs = rs; ID_Rt = rt;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      total++;
      if (EX_Valid === e.v && ALUOperation === e.op &&
          A === e.a && B === e.b &&
          EX_StoreData === e.sd &&
          ForwardA === e.fa && ForwardB === e.fb)
        passed++;
      else
        $display(
          "FAIL %s: got v=%b op=%h A=%h B=%h sd=%h fa=%b fb=%b want v=%b op=%h A=%h B=%h sd=%h fa=%b fb=%b",
          n, EX_Valid, ALUOperation, A, B, EX_StoreData,
          ForwardA, ForwardB, e.v, e.op, e.a, e.b, e.sd,
          e.fa, e.fb);
    end
  end

  initial begin
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    id(0, 4'h0, 0, 0, 0, 0, 0, 0);
    fwd(0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    expect_bubble("reset");

    step();
    expect_bubble("idle");
    id(1, 4'h3, 0, 32'd5, 32'd7, 32'h100, 5'd3, 5'd4);

    step();
    expect_out("add_nofwd", 1, 4'h3, 5, 7, 7, 2'b00, 2'b00);

    step();
    fwd(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    expect_out("mem_over_wb", 1, 4'h3, 32'h10, 7, 7,
               2'b10, 2'b00);
    id(1, 4'h3, 1, 32'd5, 32'd7, 32'hFFFF_FFFC, 5'd3, 5'd4);

    step();
    fwd(0, 5'd3, 32'h10, 1, 5'd3, 32'h20);
    expect_out("wb_fwd_a", 1, 4'h3, 32'h20, 32'hFFFF_FFFC, 7,
               2'b01, 2'b00);

    step();
    fwd(0, 0, 0, 1, 5'd4, 32'd9);
    expect_out("imm_wb_store", 1, 4'h3, 5, 32'hFFFF_FFFC, 9,
               2'b00, 2'b01);

    step();
    fwd(1, 5'd4, 32'h44, 1, 5'd4, 32'd9);
    expect_out("imm_mem_store", 1, 4'h3, 5, 32'hFFFF_FFFC,
               32'h44, 2'b00, 2'b10);
    id(1, 4'h4, 0, 32'd0, 32'd7, 32'd0, 5'd0, 5'd4);

    step();
    fwd(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    expect_out("reg0_nofwd", 1, 4'h4, 0, 7, 7, 2'b00, 2'b00);

    step();
    fwd(0, 5'd4, 32'h55, 0, 5'd4, 32'h66);
    expect_out("regwrite_off", 1, 4'h4, 0, 7, 7, 2'b00, 2'b00);
    fwd(0, 0, 0, 0, 0, 0);
    id(1, 4'h1, 0, 32'h11, 32'h22, 32'h0, 5'd5, 5'd6);

    step();
    expect_out("load_or", 1, 4'h1, 32'h11, 32'h22, 32'h22,
               2'b00, 2'b00);
    Stall = 1'b1;
    id(1, 4'h2, 0, 32'h99, 32'h88, 32'h0, 5'd7, 5'd8);

    step();
    expect_out("stall_hold1", 1, 4'h1, 32'h11, 32'h22, 32'h22,
               2'b00, 2'b00);

    step();
    fwd(1, 5'd5, 32'h77, 0, 0, 0);
    expect_out("stall_live_fwd", 1, 4'h1, 32'h77, 32'h22,
               32'h22, 2'b10, 2'b00);
    Flush = 1'b1;

    step();
    fwd(0, 0, 0, 0, 0, 0);
    expect_bubble("flush_over_stall");
    Flush = 1'b0;
    Stall = 1'b0;

    step();
    expect_out("load_nor", 1, 4'h2, 32'h99, 32'h88, 32'h88,
               2'b00, 2'b00);
    Stall = 1'b1;
    id(1, 4'h0, 0, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2);

    step();
    expect_out("stall_hold2", 1, 4'h2, 32'h99, 32'h88, 32'h88,
               2'b00, 2'b00);
    reset = 1'b1;

    step();
    expect_bubble("reset_mid_stall");
    reset = 1'b0;
    Stall = 1'b0;
    Flush = 1'b1;

    step();
    expect_bubble("flush_alone");
    Flush = 1'b0;

    step();
    expect_out("load_and", 1, 4'h0, 32'h1, 32'h2, 32'h2,
               2'b00, 2'b00);
    id(0, 4'h3, 0, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2);

    step();
    expect_bubble("id_invalid");

    step();
    step();
    total++;
    if (q.size() == 0)
      passed++;
    else
      $display("FAIL drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
